// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if: single-cycle-ready word bus between the SoC memory arbiter and the UART receiver.
interface uart_rx_mmio_if;
    logic        valid;
    logic        write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    modport master(output valid, write, addr, wdata, input rdata, ready);
    modport slave(input valid, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: oversampling UART receiver (8N1, LSB first) with receive FIFO, MMIO registers and irq.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err status flag.
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          rx,
    uart_rx_mmio_if.slave bus,
    output logic          irq
);
    localparam int cnt_w = $clog2(CLKS_PER_BIT);
    localparam int ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [cnt_w-1:0] cnt_half = cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [cnt_w-1:0] cnt_bit = cnt_w'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    state_t state, state_n;
    logic rx_m, rx_s;
    logic [cnt_w-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shift, shift_n;
    logic push, frame_set, par_set;
    logic [7:0] mem [FIFO_DEPTH];
    logic [ptr_w-1:0] wr_ptr, rd_ptr;
    logic [ptr_w:0] count;
    logic frame_err, overrun, par_err;
    logic accept, pop, do_push, full, nonempty;
    logic [2:0] clr;
    logic [31:0] rd_val;
    logic unused;
    always_ff @(posedge clk)
        if (!resetn) {rx_m, rx_s} <= 2'b11;
        else {rx_m, rx_s} <= {rx, rx_m};
    always_ff @(posedge clk)
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            shift <= shift_n;
        end
    always_comb begin
        state_n = state;
        cnt_n = (cnt == '0) ? cnt_bit : cnt - cnt_w'(1);
        idx_n = idx;
        shift_n = shift;
        push = 1'b0;
        frame_set = 1'b0;
        par_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = cnt_half;
                state_n = rx_s ? IDLE : START;
            end
            START: if (cnt == '0) begin
                state_n = rx_s ? IDLE : DATA;
                idx_n = '0;
            end
            DATA: if (cnt == '0) begin
                shift_n[idx] = rx_s;
                idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx == 3'd7) state_n = PARITY;
`else
                if (idx == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == '0) begin
                par_set = rx_s ^ (^shift);
                state_n = STOP;
            end
`endif
            STOP: if (cnt == '0) begin
                push = rx_s;
                frame_set = !rx_s;
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            // a held-low line must return high before a new start bit counts
            WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
            default: state_n = IDLE;
        endcase
    end
    assign full = count == (ptr_w + 1)'(FIFO_DEPTH);
    assign nonempty = count != '0;
    assign accept = bus.valid && !bus.ready;
    assign pop = accept && !bus.write && bus.addr[3:2] == 2'd0 && nonempty;
    assign do_push = push && (!full || pop);
    assign clr = (accept && bus.write && bus.addr[3:2] == 2'd1) ? bus.wdata[5:3] : 3'b000;
    assign rd_val = (bus.addr[3:2] == 2'd0) ? (nonempty ? {23'b0, 1'b1, mem[rd_ptr]} : 32'b0) :
                    (bus.addr[3:2] == 2'd1) ? {26'b0, par_err, overrun, frame_err, full, nonempty, state != IDLE} :
                    (bus.addr[3:2] == 2'd2) ? 32'(count) : 32'b0;
    assign unused = ^{bus.wdata[31:6], bus.wdata[2:0], bus.addr[1:0]};
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= shift;
    always_ff @(posedge clk)
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
            par_err <= 1'b0;
            irq <= 1'b0;
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_w'(do_push);
            rd_ptr <= rd_ptr + ptr_w'(pop);
            count <= count + (ptr_w + 1)'(do_push) - (ptr_w + 1)'(pop);
            frame_err <= frame_set | (frame_err & ~clr[0]);
            overrun <= (push && full && !pop) | (overrun & ~clr[1]);
            par_err <= par_set | (par_err & ~clr[2]);
            irq <= nonempty;
            bus.ready <= accept;
            if (accept) bus.rdata <= bus.write ? 32'b0 : rd_val;
        end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: scoreboard bench for uart_rx_mmio at CLKS_PER_BIT=4, FIFO_DEPTH=8 (8N1 build).
module tb_uart_rx_mmio;
    localparam int CPB = 4;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rx = 1'b1;
    logic irq;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    uart_rx_mmio_if bus();
    uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rx(rx), .bus(bus), .irq(irq)
    );
    always #5 clk = ~clk;

    // one bus transaction started on a negedge; lat = negedges until ready, -1 on timeout
    task automatic access(input logic w, input logic [3:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        bus.valid = 1'b1;
        bus.write = w;
        bus.addr = a;
        bus.wdata = wd;
        lat = -1;
        rd = 'x;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat = i;
                rd = bus.rdata;
            end
        end
        bus.valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        resetn = 1'b0;
        bus.valid = 1'b0;
        bus.write = 1'b0;
        bus.addr = 4'h0;
        bus.wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
        resetn = 1'b1;
        @(negedge clk);
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h want 0", rd); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_count got %h want 0", rd); end
    endtask

    task automatic test_single();
        logic [31:0] rd, exp;
        int lat;
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(32'h0000_01A5);
        repeat (4) @(negedge clk);
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL single_count got %h want 1", rd); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL single_irq got %b want 1", irq); end
        access(1'b0, 4'h0, 32'h0, rd, lat);
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'h0;
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL single_data got %h want %h", rd, exp); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_latency got %0d want 1", lat); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL single_irq_clear got %b want 0", irq); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL single_count_after got %h want 0", rd); end
    endtask

    task automatic test_empty_read();
        logic [31:0] rd;
        int lat;
        access(1'b0, 4'h0, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL empty_data got %h want 0", rd); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL empty_latency got %0d want 1", lat); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL empty_count got %h want 0", rd); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd, exp;
        int lat;
        for (int b = 1; b <= DEPTH + 1; b++) begin
            send_frame(8'(b), 1'b1);
            if (b <= DEPTH) exp_q.push_back({23'b0, 1'b1, 8'(b)});
        end
        repeat (4) @(negedge clk);
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h16) begin n_bad++; $display("FAIL ovr_status got %h want 16", rd); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'(DEPTH)) begin n_bad++; $display("FAIL ovr_count got %h want %h", rd, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 4'h0, 32'h0, rd, lat);
            exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'h0;
            n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL ovr_data[%0d] got %h want %h", i, rd, exp); end
        end
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h10) begin n_bad++; $display("FAIL ovr_status_drained got %h want 10", rd); end
        access(1'b1, 4'h4, 32'h10, rd, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ovr_w1c_latency got %0d want 1", lat); end
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL ovr_status_cleared got %h want 0", rd); end
    endtask

    task automatic test_frame_err();
        logic [31:0] rd, exp;
        int lat;
        send_frame(8'h77, 1'b0);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h09) begin n_bad++; $display("FAIL ferr_status_low got %h want 09", rd); end
        repeat (28) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(32'h0000_013C);
        repeat (4) @(negedge clk);
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0A) begin n_bad++; $display("FAIL ferr_status got %h want 0a", rd); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL ferr_count got %h want 1", rd); end
        access(1'b0, 4'h0, 32'h0, rd, lat);
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'h0;
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL ferr_data got %h want %h", rd, exp); end
        access(1'b1, 4'h4, 32'h08, rd, lat);
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL ferr_cleared got %h want 0", rd); end
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        int lat;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h01) begin n_bad++; $display("FAIL glitch_busy got %h want 01", rd); end
        repeat (10) @(negedge clk);
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL glitch_status got %h want 0", rd); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL glitch_count got %h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp;
        int lat;
        send_frame(8'h81, 1'b1);
        exp_q.push_back(32'h0000_0181);
        repeat (4) @(negedge clk);
        access(1'b1, 4'h0, 32'hFF, rd, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_wdata_latency got %0d want 1", lat); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL b2b_count got %h want 1", rd); end
        access(1'b0, 4'hC, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0 || lat !== 1) begin n_bad++; $display("FAIL b2b_reg3 got %h/%0d want 0/1", rd, lat); end
        access(1'b1, 4'hC, 32'hFFFF_FFFF, rd, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_reg3_write_latency got %0d want 1", lat); end
        access(1'b0, 4'h0, 32'h0, rd, lat);
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'h0;
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL b2b_data got %h want %h", rd, exp); end
        access(1'b0, 4'h0, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL b2b_single_pop got %h want 0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp;
        int lat;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'd3) begin n_bad++; $display("FAIL rmid_count_before got %h want 3", rd); end
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rmid_irq got %b want 0", irq); end
        access(1'b0, 4'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rmid_count got %h want 0", rd); end
        access(1'b0, 4'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rmid_status got %h want 0", rd); end
        send_frame(8'h5A, 1'b1);
        exp_q.push_back(32'h0000_015A);
        repeat (4) @(negedge clk);
        access(1'b0, 4'h0, 32'h0, rd, lat);
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'h0;
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rmid_data got %h want %h", rd, exp); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty_read();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped UART receiver (8N1, LSB first) for the PicoRV32 SoC; the receive-side counterpart of the existing TX path.
- Oversamples an asynchronous rx pin, assembles bytes, and buffers them in a small FIFO.
- Exposes data and status registers on a single-cycle-ready word bus for the SoC memory arbiter (IO region 0x3xxxxxxx).
- Drives a level irq while received data is pending.

Parameters:
CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); must be >= 4
FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
resetn  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial input, idle high
bus_valid  input  1  access request; held by master until bus_ready
bus_write  input  1  1 = write, 0 = read; stable while bus_valid
bus_addr  input  4  byte offset; bits [3:2] select the register
bus_wdata  input  32  write data
bus_rdata  output  32  read data; valid in the bus_ready cycle
bus_ready  output  1  one-cycle completion pulse
irq  output  1  high while FIFO is non-empty

Behaviour:
- Reset: all state is cleared in a clk edge with resetn low.
  - bus_ready=0, bus_rdata=0, irq=0.
  - FIFO empty; sticky flags cleared; FSM in IDLE.
  - Synchronizer flops set to 1.
  - Reset mid-frame discards the partial byte.
- Synchronizer: two flops on rx; the FSM uses only the synced value (2-cycle input latency).
- FSM:
  - IDLE: synced rx = 0 -> START, bit counter loaded with CLKS_PER_BIT/2 - 1.
  - START: on counter expiry, sample. If 1 -> IDLE (glitch, nothing recorded). If 0 -> DATA, counter = CLKS_PER_BIT-1, bit index = 0.
  - DATA: sample on each expiry into shift[bit index]. After bit 7 -> STOP (or PARITY when enabled).
  - STOP: sample on expiry.
    - 1 -> push byte, go to IDLE.
    - 0 -> frame_err sticky set, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until synced rx = 1, then IDLE. This prevents a break condition being read as repeated start bits.
- FIFO:
  - Push with FIFO full -> byte dropped, overrun sticky set, contents unchanged.
  - Push and pop in the same cycle both take effect, including when full (count unchanged).
  - Pointers wrap modulo FIFO_DEPTH.
- Registers (bus_addr[3:2]):
  - 0 DATA (read): {23'b0, valid, byte}. If non-empty: valid=1, head byte returned and popped. If empty: returns 0, no pop. Writes are ignored but acknowledged.
  - 1 STATUS (read): {26'b0, parity_err, overrun, frame_err, full, nonempty, busy}. busy=1 when FSM != IDLE.
  - 1 STATUS (write): write-1-to-clear for bits [5:3]. If a set and a clear hit the same cycle, set wins.
  - 2 COUNT (read): {(32-log2(FIFO_DEPTH)-1)'b0, count}, count range 0..FIFO_DEPTH.
  - 3: reads return 0; writes are ignored; both acknowledged.
- Handshake:
  - A request is accepted when bus_valid && !bus_ready.
  - bus_ready pulses exactly 1 cycle later, with bus_rdata registered.
  - Back-to-back accesses therefore take 2 cycles each.
  - Each access pops at most one byte.
  - bus_rdata holds its value outside ready cycles.
- irq = registered nonempty; it deasserts in the cycle after the pop that empties the FIFO.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state follows DATA, sampling 1 bit.
  - A mismatch with even parity sets parity_err sticky; the byte is still pushed if the stop bit is valid.
- Undefined: 8N1, no PARITY state; STATUS bit 5 reads 0 and W1C to it has no effect.

Test Plan:
- CLKS_PER_BIT=4; send 0xA5 frame -> COUNT=1, irq=1; DATA read returns 0x000001A5; then COUNT=0, irq=0 next cycle.
- Read DATA with FIFO empty -> bus_rdata=0, bus_ready 1 cycle after accept, COUNT stays 0.
- Send 9 bytes 0x01..0x09 without reading (depth 8) -> STATUS overrun=1, full=1; reads return 0x01..0x08 in order; write 0x10 to STATUS clears overrun.
- Frame with stop bit 0 and rx held low 40 cycles, then idle, then 0x3C -> frame_err=1, only 0x3C in FIFO.
- rx low pulse of 1 cycle (shorter than CLKS_PER_BIT/2) -> no byte, no flags, busy returns to 0.
- Assert resetn=0 mid-DATA with 3 bytes queued -> COUNT=0, STATUS=0, irq=0; next full frame 0x5A received correctly.
